// File: rtl/baud_tick_if.sv
// baud_tick_if: rate select / resync inputs and tick outputs of the baud tick
// generator. The custom_inc signal exists only when BAUD_CUSTOM_EN is defined.
interface baud_tick_if #(
    parameter int ACC_W = 24
) ();
    logic [1:0]       baud_sel;
    logic             rx_resync;
`ifdef BAUD_CUSTOM_EN
    logic [ACC_W-1:0] custom_inc;
`endif
    logic             os_tick;
    logic             bit_tick;
    logic             active;

    // master drives the rate/resync controls, slave is the generator
    modport master (
        output baud_sel,
        output rx_resync,
`ifdef BAUD_CUSTOM_EN
        output custom_inc,
`endif
        input  os_tick,
        input  bit_tick,
        input  active
    );

    modport slave (
        input  baud_sel,
        input  rx_resync,
`ifdef BAUD_CUSTOM_EN
        input  custom_inc,
`endif
        output os_tick,
        output bit_tick,
        output active
    );
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional phase-accumulator baud tick generator.
// os_tick pulses at OVERSAMPLE x baud, bit_tick on every OVERSAMPLE-th os_tick.
// Optional feature macro: BAUD_CUSTOM_EN adds custom_inc, used when baud_sel
// is 2'b00 (custom_inc == 0 means off).
module baud_tick_gen #(
    parameter int CLK_HZ     = 50000000,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24,
    parameter int BAUD_1     = 9600,
    parameter int BAUD_2     = 57600,
    parameter int BAUD_3     = 115200
) (
    input logic        clock,
    input logic        reset,
    baud_tick_if.slave bus
);
    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(OVERSAMPLE - 1);

    // Rounded increment: (baud * OVERSAMPLE * 2^ACC_W + CLK_HZ/2) / CLK_HZ
    function automatic logic [63:0] calc_inc(input logic [63:0] baud);
        return (((baud * 64'(OVERSAMPLE)) << ACC_W) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
    endfunction

    function automatic bit inc_bad(input logic [63:0] inc);
        return (inc == 64'd0) || (inc >= (64'd1 << ACC_W));
    endfunction

    localparam logic [63:0] INC_1_W = calc_inc(64'(BAUD_1));
    localparam logic [63:0] INC_2_W = calc_inc(64'(BAUD_2));
    localparam logic [63:0] INC_3_W = calc_inc(64'(BAUD_3));

    localparam logic [ACC_W-1:0] INC_1 = INC_1_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_2 = INC_2_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_3 = INC_3_W[ACC_W-1:0];

    if (inc_bad(INC_1_W) || inc_bad(INC_2_W) || inc_bad(INC_3_W)) begin : g_bad_inc
        $error("baud_tick_gen: a rate increment is zero or does not fit in ACC_W bits");
    end

    if (OVERSAMPLE < 2 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("baud_tick_gen: OVERSAMPLE must be a power of two >= 2");
    end

    logic [1:0]       sel_q;
    logic [ACC_W-1:0] acc;
    logic [SUB_W-1:0] sub_cnt;
    logic             os_q;
    logic             bit_q;
    logic             active_q;

    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic             sel_change;
    logic             nxt_active;
    logic             running;

`ifdef BAUD_CUSTOM_EN
    logic [ACC_W-1:0] cust_q;

    // last-seen custom increment, so a change while on 2'b00 restarts the phase
    always_ff @(posedge clock) begin
        if (reset) cust_q <= '0;
        else       cust_q <= bus.custom_inc;
    end
`endif

    // increment for the registered rate, and detection of a rate change
    always_comb begin
        inc = '0;
        unique case (sel_q)
            2'b01:   inc = INC_1;
            2'b10:   inc = INC_2;
            2'b11:   inc = INC_3;
            default: begin
`ifdef BAUD_CUSTOM_EN
                inc = cust_q;
`else
                inc = '0;
`endif
            end
        endcase
`ifdef BAUD_CUSTOM_EN
        sel_change = (bus.baud_sel != sel_q) ||
                     (sel_q == 2'b00 && bus.custom_inc != cust_q);
        nxt_active = (bus.baud_sel != 2'b00) || (bus.custom_inc != '0);
`else
        sel_change = (bus.baud_sel != sel_q);
        nxt_active = (bus.baud_sel != 2'b00);
`endif
        // a zero increment is the "off" state
        running = (inc != '0);
        sum     = {1'b0, acc} + {1'b0, inc};
    end

    // phase accumulator, sub-bit counter and registered tick outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q    <= 2'b00;
            acc      <= '0;
            sub_cnt  <= '0;
            os_q     <= 1'b0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
        end else if (sel_change) begin
            // one tick-free clear cycle; takes precedence over rx_resync
            sel_q    <= bus.baud_sel;
            acc      <= '0;
            sub_cnt  <= '0;
            os_q     <= 1'b0;
            bit_q    <= 1'b0;
            active_q <= nxt_active;
        end else if (!running) begin
            acc      <= '0;
            sub_cnt  <= '0;
            os_q     <= 1'b0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
        end else if (bus.rx_resync) begin
            // realign: the next bit_tick is exactly OVERSAMPLE os_ticks away
            acc      <= '0;
            sub_cnt  <= '0;
            os_q     <= 1'b0;
            bit_q    <= 1'b0;
            active_q <= 1'b1;
        end else begin
            acc      <= sum[ACC_W-1:0];
            os_q     <= sum[ACC_W];
            bit_q    <= sum[ACC_W] && (sub_cnt == SUB_MAX);
            active_q <= 1'b1;
            if (sum[ACC_W]) sub_cnt <= sub_cnt + 1'b1;
        end
    end

    assign bus.os_tick  = os_q;
    assign bus.bit_tick = bit_q;
    assign bus.active   = active_q;
endmodule
